// File: rtl/bus_master_pkg.sv
// Shared types and defaults for the two-master bus requester.
package bus_master_pkg;
    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 8;
    localparam int LW_DEFAULT = 4;
    localparam int STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;
endpackage

// File: rtl/bus_beat_counter.sv
// Loadable beat address incrementer and remaining-beat down-counter.
module bus_beat_counter
    import bus_master_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int LW = LW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] load_addr,
    input  logic [LW-1:0] load_len,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic [LW-1:0] beats_left;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            beats_left <= '0;
        end else if (load) begin
            addr       <= load_addr;
            beats_left <= load_len;
        end else if (step) begin
            addr       <= addr + 1'b1;
            beats_left <= beats_left - 1'b1;
        end
    end

    assign last = (beats_left == '0);
endmodule

// File: rtl/bus_master_if.sv
// Master-side requester: one command -> request, granted burst, one-cycle release.
// Optional grant-wait timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_if
    import bus_master_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int LW      = LW_DEFAULT,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [LW-1:0] cmd_len,
    output logic          M_request,
    input  logic          M_grant,
    output logic [AW-1:0] M_address,
    output logic          M_wr,
    output logic [DW-1:0] M_dout,
    input  logic [DW-1:0] M_din,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          done,
    output logic          err
);
    state_t        state;
    logic          wr_q;
    logic [DW-1:0] wdata_q;
    logic [AW-1:0] beat_addr;
    logic          last_beat;
    logic          beat;
    logic          load;
    logic          timeout_hit;

    assign beat = (state == XFER) && M_grant;
    assign load = (state == IDLE) && cmd_valid && cmd_ready;

    bus_beat_counter #(.AW(AW), .LW(LW)) u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (beat),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .addr      (beat_addr),
        .last      (last_beat)
    );

    // Bus side is gated live by grant so a lost grant never shows a stale beat.
    assign M_address = beat ? beat_addr : '0;
    assign M_wr      = beat & wr_q;
    assign M_dout    = beat ? wdata_q : '0;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if ((state == REQ) && !M_grant)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign timeout_hit = (state == REQ) && !M_grant && (wait_cnt == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            M_request <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        wr_q      <= cmd_wr;
                        wdata_q   <= cmd_wdata;
                        M_request <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (M_grant) begin
                        state <= XFER;
                    end else if (timeout_hit) begin
                        M_request <= 1'b0;
                        cmd_ready <= 1'b1;
                        err       <= 1'b1;
                        state     <= IDLE;
                    end
                end
                XFER: begin
                    if (M_grant) begin
                        if (!wr_q) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= M_din;
                        end
                        if (last_beat) begin
                            M_request <= 1'b0;
                            done      <= 1'b1;
                            state     <= RELEASE;
                        end
                    end else begin
                        state <= REQ;
                    end
                end
                RELEASE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
